alu_mul_seq: RTL

- Iterative shift-add multiplier controller that sequences the shared N-bit ALU.
- The ALU has no multiply op, so this block computes the low N bits of a*b through repeated ALU add (4'b0010) and pass-B (4'b0111) operations.
- It drives the ALU operand/control inputs and consumes the ALU result and zero flag.
- It sits beside the ALU and uses a start/done handshake toward the requester, for example a multi-cycle MUL in the execute stage.

---
 rtl/alu_mul_seq.sv | 71 +++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier that sequences a shared ALU through add and pass-b ops
module alu_mul_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero
);
  typedef enum logic [1:0] {IDLE, TEST, ADD, DONE} state_t;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;
  state_t state_q, state_d;
  logic [N-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, product_q, product_d;
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = op_a;
        mplier_d = op_b;
        acc_d    = '0;
        state_d  = TEST;
      end
      TEST: begin
        state_d   = alu_zero ? DONE : ADD;
        product_d = alu_zero ? acc_q : product_q;
      end
      ADD: begin
        acc_d    = mplier_q[0] ? alu_result : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        state_d  = TEST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end
  assign busy     = (state_q == TEST) || (state_q == ADD);
  assign done     = state_q == DONE;
  assign product  = product_q;
  assign alu_a    = busy ? acc_q : '0;
  assign alu_b    = (state_q == TEST) ? mplier_q : (state_q == ADD) ? mcand_q : '0;
  assign alu_ctrl = (state_q == TEST) ? CTRL_PASSB : (state_q == ADD) ? CTRL_ADD : 4'b0000;
endmodule
